// File: rtl/pong_game_controller.sv
// pong_game_controller: frame-tick pacing, serve delay, goal detection, scoring and winner for Pong.
module pong_game_controller #(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int LEFT_GOAL    = 2,
  parameter int RIGHT_GOAL   = 637,
  parameter int BALL_SIZE    = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       endofframe,
  input  logic       start_btn,
  input  logic [9:0] ball_x,
  output logic       move_en,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t st;
  logic [7:0] serve_cnt;
  logic ef_d, start_d, frame_tick, start_pe, goal_r, goal_l;
  assign frame_tick = endofframe & ~ef_d;
  assign start_pe   = start_btn & ~start_d;
  // an underflowed ball_x wraps to a large value, so it counts as a left-side goal
  assign goal_r = (ball_x <= 10'(LEFT_GOAL)) || (ball_x > 10'd639);
  assign goal_l = ~goal_r && (({1'b0, ball_x} + 11'(BALL_SIZE - 1)) >= 11'(RIGHT_GOAL));
  assign move_en   = frame_tick && st == PLAY && !goal_r && !goal_l;
  assign ball_hold = st != PLAY;
  assign game_over = st == OVER;
  assign state     = st;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= IDLE;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b1;
      serve_cnt   <= '0;
      ef_d        <= 1'b0;
      start_d     <= 1'b0;
    end else begin
      ef_d    <= endofframe;
      start_d <= start_btn;
      case (st)
        IDLE, OVER: if (start_pe) begin
          st          <= SERVE;
          score_left  <= '0;
          score_right <= '0;
          serve_cnt   <= '0;
          serve_dir   <= 1'b1;
        end
        SERVE: if (frame_tick) begin
          st        <= serve_cnt == SERVE_LAST ? PLAY : SERVE;
          serve_cnt <= serve_cnt == SERVE_LAST ? 8'd0 : serve_cnt + 8'd1;
        end
        PLAY: if (frame_tick && goal_r) begin
          score_right <= score_right + 4'd1;
          serve_dir   <= 1'b0;
          st          <= POINT;
        end else if (frame_tick && goal_l) begin
          score_left <= score_left + 4'd1;
          serve_dir  <= 1'b1;
          st         <= POINT;
        end
        POINT: begin
          st        <= (score_left == WIN || score_right == WIN) ? OVER : SERVE;
          serve_cnt <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_controller.sv
// tb_pong_game_controller: directed scenarios plus randomized play against a rule-level game model.
module tb_pong_game_controller;
  localparam int SF = 3;
  logic clk = 0, reset_n = 0, endofframe = 0, start_btn = 0;
  logic [9:0] ball_x = 10'd300;
  logic move_en, ball_hold, serve_dir, game_over;
  logic [3:0] score_left, score_right;
  logic [2:0] state;
  int tests = 0, fails = 0, moves = 0;
  // model: game phase (0 idle,1 serve,2 play,3 point,4 over), scores, direction, serve frames seen
  int m_ph, m_sl, m_sr, m_dir, m_frames;
  logic m_ef_prev, m_sb_prev;

  pong_game_controller #(.SERVE_FRAMES(SF)) dut (
    .clk(clk), .reset_n(reset_n), .endofframe(endofframe), .start_btn(start_btn),
    .ball_x(ball_x), .move_en(move_en), .ball_hold(ball_hold), .serve_dir(serve_dir),
    .score_left(score_left), .score_right(score_right), .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_sl = 0; m_sr = 0; m_dir = 1; m_frames = 0; m_ef_prev = 0; m_sb_prev = 0;
  endtask

  task automatic check_regs();
    chk("state", 32'(state), 32'(m_ph));
    chk("score_left", 32'(score_left), 32'(m_sl));
    chk("score_right", 32'(score_right), 32'(m_sr));
    chk("serve_dir", 32'(serve_dir), 32'(m_dir));
    chk("ball_hold", 32'(ball_hold), 32'(m_ph != 2));
    chk("game_over", 32'(game_over), 32'(m_ph == 4));
  endtask

  task automatic cyc(input logic ef, input logic sb, input logic [9:0] bx);
    bit tick, press, right_goal, left_goal;
    @(negedge clk);
    endofframe = ef; start_btn = sb; ball_x = bx;
    #1;
    tick = ef && !m_ef_prev;
    press = sb && !m_sb_prev;
    right_goal = bx <= 2 || bx > 639;
    left_goal = !right_goal && (int'(bx) + 9 >= 637);
    chk("move_en", 32'(move_en), 32'(tick && m_ph == 2 && !right_goal && !left_goal));
    moves += int'(move_en);
    @(posedge clk);
    case (m_ph)
      0, 4: if (press) begin m_ph = 1; m_sl = 0; m_sr = 0; m_frames = 0; m_dir = 1; end
      1: if (tick) begin
        m_frames++;
        if (m_frames == SF) begin m_ph = 2; m_frames = 0; end
      end
      2: if (tick && right_goal) begin m_sr++; m_dir = 0; m_ph = 3; end
         else if (tick && left_goal) begin m_sl++; m_dir = 1; m_ph = 3; end
      3: begin m_ph = (m_sl == 7 || m_sr == 7) ? 4 : 1; m_frames = 0; end
      default: m_ph = 0;
    endcase
    m_ef_prev = ef; m_sb_prev = sb;
    #1;
    check_regs();
  endtask

  task automatic frame(input logic [9:0] bx, input logic sb);
    cyc(1, sb, bx);
    cyc(0, sb, bx);
  endtask

  task automatic serve_to_play();
    repeat (SF) frame(10'd300, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    endofframe = 0; start_btn = 0;
    #2 reset_n = 0;
    #1 model_reset();
    chk("rst_state", 32'(state), 0);
    chk("rst_scores", {24'd0, score_left, score_right}, 0);
    chk("rst_ball_hold", 32'(ball_hold), 1);
    chk("rst_move_en", 32'(move_en), 0);
    check_regs();
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    cyc(0, 0, 10'd300);
    cyc(0, 1, 10'd300);
    cyc(0, 0, 10'd300);
    serve_to_play();
    chk("in_play", 32'(state), 2);
    moves = 0;
    repeat (5) cyc(1, 0, 10'd300);
    cyc(0, 0, 10'd300);
    chk("move_once", 32'(moves), 1);
    frame(10'd2, 0);
    chk("left_edge_goal", 32'(score_right), 1);
    serve_to_play();
    frame(10'd628, 0);
    chk("right_edge_goal", 32'(score_left), 1);
    serve_to_play();
    frame(10'd627, 0);
    chk("no_goal_627", 32'(state), 2);
    frame(10'd1020, 0);
    chk("wrap_goal", 32'(score_right), 2);
    serve_to_play();
    frame(10'd630, 0);
    serve_to_play();
    frame(10'd630, 0);
    serve_to_play();
    chk("score_3_2", {24'd0, score_left, score_right}, 32'h32);
    do_reset();
    cyc(0, 1, 10'd300);
    for (int i = 0; i < 60 && !game_over; i++) frame(10'd630, 0);
    chk("win_over", 32'(game_over), 1);
    chk("win_score", 32'(score_left), 7);
    repeat (3) frame(10'd2, 0);
    chk("frozen", {24'd0, score_left, score_right}, 32'h70);
    repeat (SF + 1) frame(10'd300, 1);
    chk("held_start_play", 32'(state), 2);
    frame(10'd2, 1);
    serve_to_play();
    chk("held_start_scores", {24'd0, score_left, score_right}, 32'h01);
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [9:0] bx;
      if ($urandom_range(0, 799) == 0) do_reset();
      r = int'($urandom_range(0, 9));
      bx = r == 0 ? 10'($urandom_range(0, 2)) : r == 1 ? 10'($urandom_range(627, 639)) :
           r == 2 ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(3, 626));
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0), bx);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
